// File: rtl/mux_wb_pipe_if.sv
// mux_wb_pipe_if: handshake and data bundle between the write-back sources, mux_wb_pipe and the register file.
// The master modport is the upstream/downstream environment; slave is the selector stage.
interface mux_wb_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 10,
    parameter int SEL_W   = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          sel;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [2:0]                ext_mode;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      sel_err;
    logic                      err_clr;
    logic [15:0]               xfer_cnt;

    modport master (
        output in_valid, sel, src_data, ext_mode, out_ready, err_clr,
        input  in_ready, out_valid, out_data, out_sel, sel_err, xfer_cnt
    );

    modport slave (
        input  in_valid, sel, src_data, ext_mode, out_ready, err_clr,
        output in_ready, out_valid, out_data, out_sel, sel_err, xfer_cnt
    );
endinterface

// File: rtl/mux_wb_pipe.sv
// mux_wb_pipe: registered write-back source selector with valid/ready handshake.
// Define MUX_WB_EXT_EN to add load-size extraction and sign/zero extension of the selected source.
module mux_wb_pipe #(
    parameter int          DATA_W    = 32,
    parameter int          NUM_SRC   = 10,
    parameter int          SEL_W     = 4,
    parameter logic [31:0] CONST_VAL = 32'd227
) (
    input  logic          clk,
    input  logic          reset,
    mux_wb_pipe_if.slave  bus
);
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              sel_err_q, sel_err_d;
    logic [15:0]       xfer_cnt_q, xfer_cnt_d;
    logic [DATA_W-1:0] src_sel, ext_val, res;
    logic              accept, sel_oob, ext_bad, err;

    assign bus.in_ready = !out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        src_sel = '0;
        for (int k = 1; k <= NUM_SRC; k++)
            if (bus.sel == SEL_W'(k)) src_sel = bus.src_data[(k-1)*DATA_W +: DATA_W];
    end

`ifdef MUX_WB_EXT_EN
    always_comb begin
        ext_bad = bus.ext_mode > 3'd4;
        ext_val = bus.ext_mode == 3'd1 ? {{(DATA_W-8){src_sel[7]}}, src_sel[7:0]} :
                  bus.ext_mode == 3'd2 ? {{(DATA_W-8){1'b0}}, src_sel[7:0]} :
                  bus.ext_mode == 3'd3 ? {{(DATA_W-16){src_sel[15]}}, src_sel[15:0]} :
                  bus.ext_mode == 3'd4 ? {{(DATA_W-16){1'b0}}, src_sel[15:0]} :
                  src_sel;
    end
`else
    logic unused_ext_mode;
    assign unused_ext_mode = ^bus.ext_mode;
    assign ext_bad = 1'b0;
    assign ext_val = src_sel;
`endif

    // The constant path bypasses extension; out-of-range selectors yield zero.
    assign sel_oob = bus.sel > SEL_W'(NUM_SRC);
    assign err     = sel_oob | ((bus.sel != '0) & ext_bad);
    assign res     = bus.sel == '0 ? DATA_W'(CONST_VAL) : sel_oob ? '0 : ext_val;

    always_comb begin
        out_valid_d = accept | (out_valid_q & !bus.out_ready);
        out_data_d  = accept ? res : out_data_q;
        out_sel_d   = accept ? bus.sel : out_sel_q;
        sel_err_d   = (accept & err) ? 1'b1 : bus.err_clr ? 1'b0 : sel_err_q;
        xfer_cnt_d  = (accept & ~&xfer_cnt_q) ? xfer_cnt_q + 16'd1 : xfer_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            sel_err_q   <= sel_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.xfer_cnt  = xfer_cnt_q;
endmodule

// File: tb/tb_mux_wb_pipe.sv
// tb_mux_wb_pipe: directed vector table plus hand-written stall, error and reset sequences for mux_wb_pipe.
module tb_mux_wb_pipe;
    localparam int DW = 32, NS = 10, SW = 4;
`ifdef MUX_WB_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mux_wb_pipe_if #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW)) bus ();
    mux_wb_pipe #(.DATA_W(DW), .NUM_SRC(NS), .SEL_W(SW), .CONST_VAL(32'd227)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [3:0]  sel;
        logic [2:0]  ext;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t        vt[12];
    logic [31:0] src[1:NS];
    int          total = 0, bad = 0, exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic [3:0] s);
        chk({tag, " out_valid"}, bus.out_valid, v);
        chk({tag, " out_data"}, bus.out_data, d);
        chk({tag, " out_sel"}, bus.out_sel, s);
        chk({tag, " xfer_cnt"}, bus.xfer_cnt, exp_cnt);
    endtask

    initial begin
        for (int k = 1; k <= NS; k++) src[k] = 32'h0101_0101 * k;
        src[1] = 32'h0000_80F0;
        src[3] = 32'h1234_5678;
        src[10] = 32'hDEAD_BEEF;
        for (int k = 1; k <= NS; k++) bus.src_data[(k-1)*DW +: DW] = src[k];

        vt[0]  = '{4'd0,  3'd0, 32'd227, 1'b0};
        vt[1]  = '{4'd3,  3'd0, 32'h1234_5678, 1'b0};
        vt[2]  = '{4'd10, 3'd0, 32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{4'd2,  3'd1, EXT ? 32'h0000_0002 : 32'h0202_0202, 1'b0};
        vt[4]  = '{4'd5,  3'd0, 32'h0505_0505, 1'b0};
        vt[5]  = '{4'd1,  3'd0, 32'h0000_80F0, 1'b0};
        vt[6]  = '{4'd1,  3'd1, EXT ? 32'hFFFF_FFF0 : 32'h0000_80F0, 1'b0};
        vt[7]  = '{4'd1,  3'd2, EXT ? 32'h0000_00F0 : 32'h0000_80F0, 1'b0};
        vt[8]  = '{4'd1,  3'd3, EXT ? 32'hFFFF_80F0 : 32'h0000_80F0, 1'b0};
        vt[9]  = '{4'd1,  3'd4, 32'h0000_80F0, 1'b0};
        vt[10] = '{4'd7,  3'd3, EXT ? 32'h0000_0707 : 32'h0707_0707, 1'b0};
        vt[11] = '{4'd1,  3'd7, 32'h0000_80F0, EXT};

        bus.in_valid = 1'b0;
        bus.sel = '0;
        bus.ext_mode = '0;
        bus.out_ready = 1'b1;
        bus.err_clr = 1'b0;

        // Power-on reset state
        tick;
        chk_out("reset", 1'b0, 32'h0, 4'h0);
        chk("reset sel_err", bus.sel_err, 1'b0);
        chk("reset in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        tick;

        // Back-to-back accepts from the vector table; every cycle must produce a result
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.sel = vt[i].sel;
            bus.ext_mode = vt[i].ext;
            tick;
            exp_cnt++;
            chk_out($sformatf("vec%0d", i), 1'b1, vt[i].data, vt[i].sel);
            chk($sformatf("vec%0d sel_err", i), bus.sel_err, vt[i].err);
            chk($sformatf("vec%0d in_ready", i), bus.in_ready, 1'b1);
        end

        // Drain with no new accept: data/sel hold, valid drops
        bus.in_valid = 1'b0;
        bus.sel = 4'd9;
        bus.ext_mode = 3'd0;
        tick;
        chk_out("drain", 1'b0, 32'h0000_80F0, 4'd1);
        bus.err_clr = 1'b1;
        tick;
        bus.err_clr = 1'b0;
        chk("clr0 sel_err", bus.sel_err, 1'b0);

        // Stall for three cycles, then simultaneous drain+accept, then drain, then new accept
        bus.in_valid = 1'b1;
        bus.sel = 4'd2;
        bus.out_ready = 1'b0;
        tick;
        exp_cnt++;
        chk_out("stall0", 1'b1, 32'h0202_0202, 4'd2);
        for (int c = 1; c <= 3; c++) begin
            tick;
            chk_out($sformatf("stall%0d", c), 1'b1, 32'h0202_0202, 4'd2);
            chk($sformatf("stall%0d in_ready", c), bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release in_ready", bus.in_ready, 1'b1);
        tick;
        exp_cnt++;
        chk_out("release", 1'b1, 32'h0202_0202, 4'd2);
        bus.in_valid = 1'b0;
        tick;
        chk_out("drain2", 1'b0, 32'h0202_0202, 4'd2);
        bus.in_valid = 1'b1;
        bus.sel = 4'd4;
        tick;
        exp_cnt++;
        chk_out("after_stall", 1'b1, 32'h0404_0404, 4'd4);

        // Out-of-range selector, set-beats-clear, then clear alone
        bus.sel = 4'd11;
        tick;
        exp_cnt++;
        chk_out("sel11", 1'b1, 32'h0, 4'd11);
        chk("sel11 sel_err", bus.sel_err, 1'b1);
        bus.sel = 4'd12;
        bus.err_clr = 1'b1;
        tick;
        exp_cnt++;
        chk_out("sel12", 1'b1, 32'h0, 4'd12);
        chk("sel12+clr sel_err", bus.sel_err, 1'b1);
        bus.in_valid = 1'b0;
        tick;
        bus.err_clr = 1'b0;
        chk("clr sel_err", bus.sel_err, 1'b0);

        // Asynchronous reset while a result is stalled
        bus.in_valid = 1'b1;
        bus.sel = 4'd0;
        bus.out_ready = 1'b0;
        tick;
        exp_cnt++;
        bus.in_valid = 1'b0;
        tick;
        chk_out("pre_rst", 1'b1, 32'd227, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        chk_out("async_rst", 1'b0, 32'h0, 4'd0);
        @(negedge clk);
        reset = 1'b1;
        tick;
        chk("post_rst in_ready", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.sel = 4'd3;
        tick;
        exp_cnt++;
        chk_out("post_rst", 1'b1, 32'h1234_5678, 4'd3);
        bus.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
